// File: rtl/complex_divider.sv
// Sequential Q4.8 complex divider (a+jb)/(c+jd) with valid/ready handshakes.
// Both quotient components share one 32-step restoring division schedule.
module complex_divider (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [11:0] r_dividend,
    input  logic signed [11:0] i_dividend,
    input  logic signed [11:0] r_divisor,
    input  logic signed [11:0] i_divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [11:0] r_quotient,
    output logic signed [11:0] i_quotient,
    output logic               out_sat,
    output logic               out_dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [11:0] a;
    logic signed [11:0] b;
    logic signed [11:0] c;
    logic signed [11:0] d;

    logic [31:0] r_dvd;
    logic [31:0] i_dvd;
    logic [25:0] r_rem;
    logic [25:0] i_rem;
    logic [31:0] r_q;
    logic [31:0] i_q;
    logic [24:0] den;
    logic        r_neg;
    logic        i_neg;
    logic [4:0]  cnt;

    // Sign-extend to the product width so the multiplies are full precision
    logic signed [24:0] a_x;
    logic signed [24:0] b_x;
    logic signed [24:0] c_x;
    logic signed [24:0] d_x;
    logic signed [24:0] nr;
    logic signed [24:0] ni;
    logic signed [24:0] dd;
    logic signed [24:0] nr_abs;
    logic signed [24:0] ni_abs;

    assign a_x = {{13{a[11]}}, a};
    assign b_x = {{13{b[11]}}, b};
    assign c_x = {{13{c[11]}}, c};
    assign d_x = {{13{d[11]}}, d};

    assign nr     = a_x * c_x + b_x * d_x;
    assign ni     = b_x * c_x - a_x * d_x;
    assign dd     = c_x * c_x + d_x * d_x;
    assign nr_abs = nr[24] ? -nr : nr;
    assign ni_abs = ni[24] ? -ni : ni;

    logic [25:0] r_shift;
    logic [25:0] i_shift;
    logic [25:0] den_x;
    logic        r_ge;
    logic        i_ge;
    logic [25:0] r_rem_nxt;
    logic [25:0] i_rem_nxt;
    logic [31:0] r_q_nxt;
    logic [31:0] i_q_nxt;

    assign den_x     = {1'b0, den};
    assign r_shift   = {r_rem[24:0], r_dvd[31]};
    assign i_shift   = {i_rem[24:0], i_dvd[31]};
    assign r_ge      = r_shift >= den_x;
    assign i_ge      = i_shift >= den_x;
    assign r_rem_nxt = r_ge ? r_shift - den_x : r_shift;
    assign i_rem_nxt = i_ge ? i_shift - den_x : i_shift;
    assign r_q_nxt   = {r_q[30:0], r_ge};
    assign i_q_nxt   = {i_q[30:0], i_ge};

    // Returns {clipped, value}; negative side reaches -2048 unclipped
    function automatic logic [12:0] clip(input logic [31:0] mag,
                                         input logic        neg);
        logic [11:0] m;
        m = mag[11:0];
        if (neg) begin
            if (mag > 32'd2048) return {1'b1, 12'h800};
            return {1'b0, ~m + 12'd1};
        end
        if (mag > 32'd2047) return {1'b1, 12'h7FF};
        return {1'b0, m};
    endfunction

    logic [12:0] r_fin;
    logic [12:0] i_fin;
    logic        dbz;

    assign r_fin = clip(r_q_nxt, r_neg);
    assign i_fin = clip(i_q_nxt, i_neg);
    assign dbz   = (den == 25'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = MULT;
            MULT: state_nxt = DIV;
            DIV:  if (cnt == 5'd31) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            r_dvd      <= '0;
            i_dvd      <= '0;
            r_rem      <= '0;
            i_rem      <= '0;
            r_q        <= '0;
            i_q        <= '0;
            den        <= '0;
            r_neg      <= 1'b0;
            i_neg      <= 1'b0;
            cnt        <= '0;
            r_quotient <= '0;
            i_quotient <= '0;
            out_sat    <= 1'b0;
            out_dbz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a <= r_dividend;
                        b <= i_dividend;
                        c <= r_divisor;
                        d <= i_divisor;
                    end
                end
                MULT: begin
                    r_dvd <= {nr_abs[23:0], 8'd0};
                    i_dvd <= {ni_abs[23:0], 8'd0};
                    den   <= dd;
                    r_neg <= nr[24];
                    i_neg <= ni[24];
                    r_rem <= '0;
                    i_rem <= '0;
                    r_q   <= '0;
                    i_q   <= '0;
                    cnt   <= '0;
                end
                DIV: begin
                    r_dvd <= {r_dvd[30:0], 1'b0};
                    i_dvd <= {i_dvd[30:0], 1'b0};
                    r_rem <= r_rem_nxt;
                    i_rem <= i_rem_nxt;
                    r_q   <= r_q_nxt;
                    i_q   <= i_q_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // Zero divisor still takes the full schedule
                        if (dbz) begin
                            r_quotient <= '0;
                            i_quotient <= '0;
                            out_sat    <= 1'b0;
                            out_dbz    <= 1'b1;
                        end else begin
                            r_quotient <= r_fin[11:0];
                            i_quotient <= i_fin[11:0];
                            out_sat    <= r_fin[12] | i_fin[12];
                            out_dbz    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
